// File: rtl/fir_pkg.sv
// Shared types for the OOK pulse link: sample/template types and transmitter states.
package fir_pkg;
  localparam int unsigned TAPS_C = 9;
  localparam int unsigned SW_C   = 4;

  typedef logic [SW_C-1:0] sample_t;
  typedef sample_t [0:TAPS_C-1] shape_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } tx_state_e;
endpackage

// File: rtl/ook_pulse_tx_if.sv
// Bit-queue and sample-bus signals of the OOK transmitter; master drives bits/strobe, slave is the transmitter.
interface ook_pulse_tx_if
  import fir_pkg::*;
#(
  parameter int unsigned TAPS = TAPS_C,
  parameter int unsigned SW   = SW_C
);
  logic [0:TAPS-1][SW-1:0] shape;
  logic                    bit_in;
  logic                    bit_valid;
  logic                    bit_ready;
  logic                    sample_en;
  logic [SW-1:0]           x_out;
  logic                    x_valid;
  logic                    sym_start;
  logic                    busy;

  modport master (
    output shape, bit_in, bit_valid, sample_en,
    input  bit_ready, x_out, x_valid, sym_start, busy
  );

  modport slave (
    input  shape, bit_in, bit_valid, sample_en,
    output bit_ready, x_out, x_valid, sym_start, busy
  );
endinterface

// File: rtl/ook_bit_fifo.sv
// DEPTH x 1-bit synchronous FIFO with first-word fall-through read and async reset.
module ook_bit_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (pop_ok) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ook_pulse_tx.sv
// OOK transmitter: one TAPS-sample symbol per queued bit, template sent time-reversed, optional zero gap.
module ook_pulse_tx
  import fir_pkg::*;
#(
  parameter int unsigned TAPS  = TAPS_C,
  parameter int unsigned SW    = SW_C,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 0
) (
  input logic          clk,
  input logic          rst,
  ook_pulse_tx_if.slave bus
);
  localparam int unsigned IW = $clog2(TAPS);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  tx_state_e               state, state_d;
  logic [IW-1:0]           idx, idx_d, rev_idx;
  logic [GW-1:0]           gcnt, gcnt_d;
  logic [0:TAPS-1][SW-1:0] shadow, shadow_d;
  logic                    cur_bit, cur_bit_d;
  logic [SW-1:0]           x_d;
  logic                    x_valid_d;
  logic                    sym_start_d;
  logic                    start_sym;
  logic                    pop;
  logic                    fifo_dout;
  logic                    full;
  logic                    empty;

  ook_bit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.bit_valid),
    .din   (bus.bit_in),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  assign bus.bit_ready = ~full;
  assign rev_idx       = IW'(TAPS - 1) - idx;

  // SEND with idx == 0 means a queued bit is waiting for the next strobe (back-to-back start).
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    gcnt_d      = gcnt;
    shadow_d    = shadow;
    cur_bit_d   = cur_bit;
    x_d         = bus.x_out;
    x_valid_d   = 1'b0;
    sym_start_d = 1'b0;
    start_sym   = 1'b0;
    pop         = 1'b0;
    if (bus.sample_en) begin
      unique case (state)
        S_IDLE: begin
          if (!empty) start_sym = 1'b1;
          else        x_d       = '0;
        end
        S_SEND: begin
          if (idx == '0) begin
            start_sym = 1'b1;
          end else begin
            x_d       = cur_bit ? shadow[rev_idx] : '0;
            x_valid_d = 1'b1;
            if (idx == IW'(TAPS - 1)) begin
              idx_d = '0;
              if (GAP > 0) begin
                state_d = S_GAP;
                gcnt_d  = '0;
              end else begin
                state_d = empty ? S_IDLE : S_SEND;
              end
            end else begin
              idx_d = idx + 1'b1;
            end
          end
        end
        S_GAP: begin
          x_d       = '0;
          x_valid_d = 1'b1;
          if (gcnt == GW'(GAP - 1)) begin
            idx_d   = '0;
            state_d = empty ? S_IDLE : S_SEND;
          end else begin
            gcnt_d = gcnt + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (start_sym) begin
      pop         = 1'b1;
      cur_bit_d   = fifo_dout;
      shadow_d    = bus.shape;
      x_d         = fifo_dout ? bus.shape[TAPS-1] : '0;
      x_valid_d   = 1'b1;
      sym_start_d = 1'b1;
      idx_d       = IW'(1);
      state_d     = S_SEND;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      gcnt          <= '0;
      shadow        <= '0;
      cur_bit       <= 1'b0;
      bus.x_out     <= '0;
      bus.x_valid   <= 1'b0;
      bus.sym_start <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      state         <= state_d;
      idx           <= idx_d;
      gcnt          <= gcnt_d;
      shadow        <= shadow_d;
      cur_bit       <= cur_bit_d;
      bus.x_out     <= x_d;
      bus.x_valid   <= x_valid_d;
      bus.sym_start <= sym_start_d;
      bus.busy      <= (state_d != S_IDLE);
    end
  end
endmodule

// File: tb/tb_ook_pulse_tx.sv
// Directed + randomized bench for ook_pulse_tx against a queue-based symbol-stream model.
module tb_ook_pulse_tx;
  import fir_pkg::*;

  localparam int TAPS  = TAPS_C;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ook_pulse_tx_if #(.TAPS(TAPS_C), .SW(SW_C)) bus ();

  ook_pulse_tx #(.TAPS(TAPS_C), .SW(SW_C), .DEPTH(DEPTH), .GAP(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: queue of accepted bits and the symbol currently being played out.
  bit      mq[$];
  int      rem;
  int      mpos;
  bit      mbit;
  bit      mstream;
  shape_t  msnap;
  logic [3:0] mx;
  bit      mvalid, mstart;

  // Receiver-side matched filter on the observed stream.
  bit      fir_on;
  int      fx[TAPS];
  shape_t  fc;
  int      pulses;
  int      nvalid;

  task automatic model_reset();
    mq.delete();
    rem = 0; mpos = 0; mbit = 0; mstream = 0;
    mx = '0; mvalid = 0; mstart = 0;
  endtask

  task automatic model_edge();
    int pre;
    bit acc;
    pre    = mq.size();
    acc    = bus.bit_valid && (pre < DEPTH);
    mvalid = 0;
    mstart = 0;
    if (bus.sample_en) begin
      if (rem == 0) begin
        if (pre > 0) begin
          mbit    = mq.pop_front();
          msnap   = bus.shape;
          rem     = TAPS;
          mpos    = 0;
          mstart  = 1;
          mstream = 1;
        end else begin
          mx = '0;
        end
      end
      if (rem > 0) begin
        mx     = mbit ? msnap[TAPS-1-mpos] : 4'd0;
        mvalid = 1;
        mpos++;
        rem--;
        if (rem == 0) mstream = (mq.size() > 0);
      end
    end
    if (acc) mq.push_back(bus.bit_in);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic observe();
    int y;
    chk("x_out",     32'(bus.x_out),     32'(mx));
    chk("x_valid",   32'(bus.x_valid),   32'(mvalid));
    chk("sym_start", 32'(bus.sym_start), 32'(mstart));
    chk("busy",      32'(bus.busy),      32'(mstream));
    chk("bit_ready", 32'(bus.bit_ready), 32'(mq.size() < DEPTH));
    if (bus.x_valid === 1'b1) begin
      nvalid++;
      if (fir_on) begin
        for (int i = TAPS - 1; i > 0; i--) fx[i] = fx[i-1];
        fx[0] = int'(bus.x_out);
        y = 0;
        for (int i = 0; i < TAPS; i++) y += fx[i] * int'(fc[i]);
        if (y > 200) pulses++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    observe();
  endtask

  task automatic drive(input bit v, input bit b, input bit en);
    bus.bit_valid = v;
    bus.bit_in    = b;
    bus.sample_en = en;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < TAPS; i++) bus.shape[i] = 4'(i + 1);
  endtask

  initial begin
    int ones;
    bus.shape = '0;
    drive(0, 0, 0);
    model_reset();
    fir_on = 0;
    pulses = 0;
    nvalid = 0;

    #2;
    chk("rst_x_out", 32'(bus.x_out), 32'd0);
    chk("rst_x_valid", 32'(bus.x_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_bit_ready", 32'(bus.bit_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // 1: single 1-bit with a ramp template
    set_ramp();
    drive(1, 1, 1);
    step();
    drive(0, 0, 1);
    repeat (12) step();
    chk("t1_idle_busy", 32'(bus.busy), 32'd0);

    // 2: 1,0,1 back-to-back
    drive(1, 1, 0); step();
    drive(1, 0, 0); step();
    drive(1, 1, 0); step();
    drive(0, 0, 1);
    nvalid = 0;
    repeat (30) step();
    chk("t2_valid_run", 32'(nvalid), 32'd27);

    // 3: fill the FIFO without strobes, then pop+push while full
    drive(1, 1, 0);
    repeat (5) step();
    chk("t3_full_ready", 32'(bus.bit_ready), 32'd0);
    drive(1, 0, 1);
    step();
    chk("t3_ready_after_pop", 32'(bus.bit_ready), 32'd1);
    drive(0, 0, 1);
    repeat (40) step();

    // 4: strobe every third cycle
    drive(1, 1, 0); step();
    drive(0, 0, 0);
    for (int k = 0; k < 36; k++) begin
      bus.sample_en = (k % 3 == 2);
      step();
    end

    // 5: reset in the middle of a 1-symbol
    drive(1, 1, 0); step();
    drive(0, 0, 1);
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("t5_rst_x_out", 32'(bus.x_out), 32'd0);
    chk("t5_rst_valid", 32'(bus.x_valid), 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    chk("t5_rst_ready", 32'(bus.bit_ready), 32'd1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    nvalid = 0;
    repeat (12) step();
    chk("t5_no_stale", 32'(nvalid), 32'd0);

    // 6: shape change mid-symbol, then closed loop into a matched filter
    drive(1, 1, 0); step();
    drive(1, 1, 0); step();
    drive(0, 0, 1);
    repeat (4) step();
    for (int i = 0; i < TAPS; i++) bus.shape[i] = 4'(15 - i);
    repeat (22) step();

    fc = {4'd1, 4'd1, 4'd1, 4'd2, 4'd15, 4'd2, 4'd1, 4'd1, 4'd1};
    bus.shape = fc;
    for (int i = 0; i < TAPS; i++) fx[i] = 0;
    fir_on = 1;
    pulses = 0;
    ones   = 0;
    drive(0, 0, 1);
    for (int k = 0; k < 12; k++) begin
      bit b;
      b = 1'($urandom_range(0, 1));
      ones += int'(b);
      bus.bit_valid = 1;
      bus.bit_in    = b;
      // bit_ready is known from the model's queue here, so accepted bits are counted exactly
      while (mq.size() >= DEPTH) begin
        bus.bit_valid = 0;
        step();
        bus.bit_valid = 1;
      end
      step();
    end
    bus.bit_valid = 0;
    repeat (TAPS * 6) step();
    fir_on = 0;
    chk("t6_fir_pulses", 32'(pulses), 32'(ones));

    // Random traffic with occasional template changes
    for (int k = 0; k < 400; k++) begin
      bus.bit_valid = ($urandom_range(0, 3) == 0);
      bus.bit_in    = 1'($urandom_range(0, 1));
      bus.sample_en = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 15) == 0)
        for (int i = 0; i < TAPS; i++) bus.shape[i] = 4'($urandom_range(0, 15));
      step();
    end
    drive(0, 0, 1);
    repeat (50) step();
    chk("final_idle_busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
